reg_bank_mp: RTL and testbench



---
 rtl/reg_bank_mp.sv | 123 ++++++++++++
 tb/tb_reg_bank_mp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_mp.sv
// Multi-port register file: two combinational read ports, two write ports,
// optional hardwired-zero r0, write-to-read bypass and a per-register busy scoreboard.
module reg_bank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              err_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wa_ok;
    logic              wb_ok;
    logic              issue_ok;
    logic              collision;

    // Writes and issues that target a hardwired-zero r0 are discarded up front.
    assign wa_ok     = wa_en    && !(ZERO_REG && (wa_addr    == '0));
    assign wb_ok     = wb_en    && !(ZERO_REG && (wb_addr    == '0));
    assign issue_ok  = issue_en && !(ZERO_REG && (issue_addr == '0));
    assign collision = wa_ok && wb_ok && (wa_addr == wb_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_ok) begin
                regs[wa_addr] <= wa_data;
            end
            // Port B is applied last so it wins a same-address collision.
            if (wb_ok) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

    // A new producer issued on the same edge as a write to that register stays busy.
    always_comb begin
        busy_next = busy;
        if (wa_ok) begin
            busy_next[wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= '0;
            err_collision <= 1'b0;
        end else begin
            busy <= busy_next;
            if (collision) begin
                err_collision <= 1'b1;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        value = regs[addr];
        if (BYPASS) begin
            if (wa_en && (wa_addr == addr)) begin
                value = wa_data;
            end
            if (wb_en && (wb_addr == addr)) begin
                value = wb_data;
            end
        end
        if (ZERO_REG && (addr == '0)) begin
            value = '0;
        end
        return value;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] addr);
        logic hit;
        hit = (wa_en && (wa_addr == addr)) || (wb_en && (wb_addr == addr));
        return busy[addr] && !(BYPASS && hit);
    endfunction

    // Outputs are held at zero while reset is low so bypassed data cannot leak out.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        rd_busy1 = 1'b0;
        rd_busy2 = 1'b0;
        if (reset) begin
            rd_data1 = read_value(rd_addr1);
            rd_data2 = read_value(rd_addr2);
            rd_busy1 = read_busy(rd_addr1);
            rd_busy2 = read_busy(rd_addr2);
        end
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Scoreboard bench for reg_bank_mp: a bypassing instance and a non-bypassing
// instance share stimulus; expectations are queued then drained each cycle.
module tb_reg_bank_mp;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic        wa_en, wb_en, issue_en;
    logic [4:0]  wa_addr, wb_addr, issue_addr;
    logic [31:0] wa_data, wb_data;
    logic        err_collision;
    logic [31:0] nb_rd_data1, nb_rd_data2;
    logic        nb_rd_busy1, nb_rd_busy2;
    logic        nb_err_collision;

    int checks = 0;
    int errors = 0;

    typedef enum int {S_DATA1, S_DATA2, S_BUSY1, S_BUSY2, S_ERR, S_NB_DATA1, S_NB_BUSY1} sel_t;
    typedef struct {
        string       tag;
        sel_t        sel;
        logic [31:0] value;
    } exp_t;
    exp_t exp_q[$];

    reg_bank_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .err_collision(err_collision)
    );

    reg_bank_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nb_rd_data1), .rd_data2(nb_rd_data2),
        .rd_busy1(nb_rd_busy1), .rd_busy2(nb_rd_busy2),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .err_collision(nb_err_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] observe(input sel_t sel);
        case (sel)
            S_DATA1:    return rd_data1;
            S_DATA2:    return rd_data2;
            S_BUSY1:    return {31'd0, rd_busy1};
            S_BUSY2:    return {31'd0, rd_busy2};
            S_ERR:      return {31'd0, err_collision};
            S_NB_DATA1: return nb_rd_data1;
            default:    return {31'd0, nb_rd_busy1};
        endcase
    endfunction

    task automatic expectValue(input string tag, input sel_t sel, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Let combinational outputs settle, then retire every queued expectation.
    task automatic drainQueue();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observe(e.sel), e.value);
        end
    endtask

    task automatic applyStimulus(input logic a_en, input logic [4:0] a_addr, input logic [31:0] a_data,
                                 input logic b_en, input logic [4:0] b_addr, input logic [31:0] b_data,
                                 input logic i_en, input logic [4:0] i_addr,
                                 input logic [4:0] r1, input logic [4:0] r2);
        wa_en = a_en;  wa_addr = a_addr;  wa_data = a_data;
        wb_en = b_en;  wb_addr = b_addr;  wb_data = b_data;
        issue_en = i_en;  issue_addr = i_addr;
        rd_addr1 = r1;  rd_addr2 = r2;
    endtask

    task automatic idleCycle(input logic [4:0] r1, input logic [4:0] r2);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, r2);
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idleCycle(5'd3, 5'd3);
        nextCycle();
        expectValue("reset_data1", S_DATA1, 32'd0);
        expectValue("reset_busy1", S_BUSY1, 32'd0);
        expectValue("reset_err", S_ERR, 32'd0);
        drainQueue();
        reset = 1'b1;

        // Populate r3 and give it an outstanding producer.
        nextCycle();
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3);
        nextCycle();
        idleCycle(5'd3, 5'd3);
        expectValue("r3_written", S_DATA1, 32'hDEADBEEF);
        expectValue("r3_busy", S_BUSY1, 32'd1);
        drainQueue();

        // Asynchronous reset mid-cycle with a write and issue pending.
        #2;
        applyStimulus(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3);
        reset = 1'b0;
        expectValue("async_reset_data1", S_DATA1, 32'd0);
        expectValue("async_reset_busy1", S_BUSY1, 32'd0);
        expectValue("async_reset_nb_data1", S_NB_DATA1, 32'd0);
        drainQueue();
        nextCycle();
        idleCycle(5'd3, 5'd3);
        reset = 1'b1;
        expectValue("post_reset_data1", S_DATA1, 32'd0);
        expectValue("post_reset_busy1", S_BUSY1, 32'd0);
        expectValue("post_reset_nb_busy1", S_NB_BUSY1, 32'd0);
        drainQueue();

        // Same-cycle bypass versus registered visibility.
        nextCycle();
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        expectValue("bypass_data1", S_DATA1, 32'h12345678);
        expectValue("nobypass_old_data1", S_NB_DATA1, 32'd0);
        drainQueue();
        nextCycle();
        idleCycle(5'd5, 5'd5);
        expectValue("nobypass_new_data1", S_NB_DATA1, 32'h12345678);
        expectValue("stored_data2", S_DATA2, 32'h12345678);
        drainQueue();

        // Register 0 ignores writes, issues and collisions.
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        expectValue("r0_bypass_data1", S_DATA1, 32'd0);
        expectValue("r0_nb_data1", S_NB_DATA1, 32'd0);
        drainQueue();
        nextCycle();
        idleCycle(5'd0, 5'd0);
        expectValue("r0_data2", S_DATA2, 32'd0);
        expectValue("r0_busy1", S_BUSY1, 32'd0);
        expectValue("r0_nb_busy1", S_NB_BUSY1, 32'd0);
        expectValue("r0_no_err", S_ERR, 32'd0);
        drainQueue();

        // Scoreboard: issue r9, write it back three cycles later on port B.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            idleCycle(5'd9, 5'd9);
            expectValue($sformatf("r9_busy_wait%0d", i), S_BUSY1, 32'd1);
            drainQueue();
        end
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9);
        expectValue("r9_wb_busy1", S_BUSY1, 32'd0);
        expectValue("r9_wb_data1", S_DATA1, 32'h55);
        expectValue("r9_wb_nb_busy1", S_NB_BUSY1, 32'd1);
        drainQueue();
        nextCycle();
        idleCycle(5'd9, 5'd9);
        expectValue("r9_after_busy1", S_BUSY1, 32'd0);
        expectValue("r9_after_nb_data1", S_NB_DATA1, 32'h55);
        drainQueue();

        // Issue and write to the same register on one edge: producer wins.
        nextCycle();
        applyStimulus(1'b1, 5'd4, 32'hCAFE0004, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd9, 5'd4);
        expectValue("r4_same_cycle_busy2", S_BUSY2, 32'd0);
        drainQueue();
        nextCycle();
        idleCycle(5'd9, 5'd4);
        expectValue("r4_busy2", S_BUSY2, 32'd1);
        expectValue("r4_data2", S_DATA2, 32'hCAFE0004);
        drainQueue();

        // Dual write collision on r7: port B wins and the flag sticks.
        nextCycle();
        applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 5'd7, 5'd7);
        expectValue("r7_bypass_priority", S_DATA1, 32'hB);
        expectValue("r7_err_before_edge", S_ERR, 32'd0);
        drainQueue();
        nextCycle();
        idleCycle(5'd7, 5'd7);
        expectValue("r7_stored", S_NB_DATA1, 32'hB);
        expectValue("r7_err_set", S_ERR, 32'd1);
        drainQueue();
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            idleCycle(5'd7, 5'd7);
            expectValue($sformatf("err_sticky%0d", i), S_ERR, 32'd1);
            drainQueue();
        end
        reset = 1'b0;
        expectValue("err_cleared", S_ERR, 32'd0);
        expectValue("r7_cleared", S_DATA1, 32'd0);
        drainQueue();
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
